// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM state encodings and requester identifiers.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_LS = 1'b1
    } owner_t;

    localparam int TIMER_W = 8;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and memory-bus signals around the arbiter.
// bus_err exists only when MEM_ARB_TIMEOUT_EN is defined.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [BE_W-1:0]   ls_be;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    logic              core_stall;

`ifdef MEM_ARB_TIMEOUT_EN
    logic              bus_err;

    // master: the arbiter itself; slave: the requesters and memory around it
    modport master (
        input  if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_ready, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata, core_stall, bus_err
    );
    modport slave (
        output if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_ready, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata, core_stall, bus_err
    );
`else
    modport master (
        input  if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_ready, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata, core_stall
    );
    modport slave (
        output if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_ready, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata, core_stall
    );
`endif

endinterface

// File: rtl/mem_port_arbiter_arb_rr2.sv
// Two-way round-robin picker: on a tie the requester not granted last wins.
// Bit 0 is fetch, bit 1 is load/store.
module arb_rr2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_gnt,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last_gnt == OWNER_LS) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store, one transaction at a time.
// Optional BUSY timeout with bus_err when MEM_ARB_TIMEOUT_EN is defined.
//
// state    | meaning
// ARB_IDLE | no access outstanding; grant a requester combinationally
// ARB_BUSY | mem_req high, waiting for mem_ready (or timeout)
// ARB_RESP | owner's rvalid/rdata presented for one cycle
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input logic                clk,
    input logic                rst,
    mem_port_arbiter_if.master bus
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t        state;
    owner_t            owner;
    owner_t            last_gnt;
    logic [1:0]        req_vec;
    logic [1:0]        pick;
    logic              pick_ls;
    logic [ADDR_W-1:0] addr_sel;
    logic              we_sel;
    logic [BE_W-1:0]   be_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic [DATA_W-1:0] resp_data;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    logic [TIMER_W-1:0] timer;
`endif

    assign req_vec = {bus.ls_req, bus.if_req};

    arb_rr2 u_arb_rr2 (
        .req      (req_vec),
        .last_gnt (last_gnt),
        .gnt      (pick)
    );

    assign pick_ls    = pick[1];
    assign bus.if_gnt = (state == ARB_IDLE) & pick[0];
    assign bus.ls_gnt = (state == ARB_IDLE) & pick[1];

    // Fetches are always full-width reads with no write data
    assign addr_sel  = pick_ls ? bus.ls_addr  : bus.if_addr;
    assign we_sel    = pick_ls & bus.ls_we;
    assign be_sel    = pick_ls ? bus.ls_be    : {BE_W{1'b1}};
    assign wdata_sel = pick_ls ? bus.ls_wdata : '0;

    assign resp_data = bus.mem_we ? '0 : bus.mem_rdata;

    assign bus.core_stall = (bus.if_req & ~bus.if_rvalid) | (bus.ls_req & ~bus.ls_rvalid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ARB_IDLE;
            owner         <= OWNER_IF;
            last_gnt      <= OWNER_IF;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.if_rvalid <= 1'b0;
            bus.if_rdata  <= '0;
            bus.ls_rvalid <= 1'b0;
            bus.ls_rdata  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            timer         <= '0;
            bus.bus_err   <= 1'b0;
`endif
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|pick) begin
                        owner         <= owner_t'(pick_ls);
                        last_gnt      <= owner_t'(pick_ls);
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= we_sel;
                        bus.mem_be    <= be_sel;
                        bus.mem_addr  <= addr_sel;
                        bus.mem_wdata <= wdata_sel;
`ifdef MEM_ARB_TIMEOUT_EN
                        timer         <= '0;
`endif
                        state         <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    // mem_ready takes priority over an expiring timer
                    if (bus.mem_ready) begin
                        bus.mem_req <= 1'b0;
                        state       <= ARB_RESP;
                        if (owner == OWNER_LS) begin
                            bus.ls_rvalid <= 1'b1;
                            bus.ls_rdata  <= resp_data;
                        end else begin
                            bus.if_rvalid <= 1'b1;
                            bus.if_rdata  <= resp_data;
                        end
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (timer == TIMER_LAST) begin
                        bus.mem_req <= 1'b0;
                        bus.bus_err <= 1'b1;
                        state       <= ARB_RESP;
                        if (owner == OWNER_LS) begin
                            bus.ls_rvalid <= 1'b1;
                        end else begin
                            bus.if_rvalid <= 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
`endif
                end
                ARB_RESP: begin
                    bus.if_rvalid <= 1'b0;
                    bus.if_rdata  <= '0;
                    bus.ls_rvalid <= 1'b0;
                    bus.ls_rdata  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
                    bus.bus_err   <= 1'b0;
`endif
                    state         <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: responses are scoreboarded when requests are issued
// and compared by a monitor when rvalid appears. Timeout cases run with MEM_ARB_TIMEOUT_EN.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        owner;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef MEM_ARB_TIMEOUT_EN
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`else
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // response monitor: pops the scoreboard on every rvalid
    always @(negedge clk) begin
        if (!rst && (bus.if_rvalid || bus.ls_rvalid)) begin
            exp_t e;
            if (sb.size() == 0) begin
                check("unexpected_rvalid", {bus.ls_rvalid, bus.if_rvalid}, 2'b00);
            end else begin
                e = sb.pop_front();
                check("rvalid_owner", {bus.ls_rvalid, bus.if_rvalid}, e.owner ? 2'b10 : 2'b01);
                check("rdata", e.owner ? bus.ls_rdata : bus.if_rdata, e.rdata);
                check("other_rdata", e.owner ? bus.if_rdata : bus.ls_rdata, 0);
`ifdef MEM_ARB_TIMEOUT_EN
                check("bus_err", bus.bus_err, e.err);
`endif
            end
        end
    end

    task automatic drive_req(input logic own, input logic we, input logic [3:0] be,
                             input logic [31:0] addr, input logic [31:0] wdata);
        if (own) begin
            bus.ls_req   = 1'b1;
            bus.ls_we    = we;
            bus.ls_be    = be;
            bus.ls_addr  = addr;
            bus.ls_wdata = wdata;
        end else begin
            bus.if_req  = 1'b1;
            bus.if_addr = addr;
        end
    endtask

    task automatic expect_gnt(input logic own);
        @(negedge clk);
        check("gnt_vec", {bus.ls_gnt, bus.if_gnt}, own ? 2'b10 : 2'b01);
        check("stall_at_gnt", bus.core_stall, 1);
    endtask

    // called from the negedge of the grant cycle; returns after dropping the owner's req
    task automatic serve(input logic own, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int delay);
        exp_t e;
        e.owner = own;
        e.rdata = (own && we) ? 32'h0 : rdata;
        e.err   = 1'b0;
        sb.push_back(e);
        @(posedge clk); #1;
        @(negedge clk);
        check("mem_req", bus.mem_req, 1);
        check("mem_we", bus.mem_we, own ? we : 1'b0);
        check("mem_be", bus.mem_be, own ? be : 4'hF);
        check("mem_addr", bus.mem_addr, addr);
        check("mem_wdata", bus.mem_wdata, own ? wdata : 32'h0);
        check("stall_busy", bus.core_stall, 1);
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("mem_req_hold", bus.mem_req, 1);
            check("stall_wait", bus.core_stall, 1);
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rdata;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = $urandom;
        @(negedge clk);
        check("rvalid_latency", own ? bus.ls_rvalid : bus.if_rvalid, 1);
        check("mem_req_drop", bus.mem_req, 0);
        check("stall_at_rvalid", bus.core_stall, own ? bus.if_req : bus.ls_req);
        @(posedge clk); #1;
        if (own) bus.ls_req = 1'b0;
        else     bus.if_req = 1'b0;
    endtask

    task automatic single(input logic own, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int delay);
        @(posedge clk); #1;
        drive_req(own, we, be, addr, wdata);
        expect_gnt(own);
        serve(own, we, be, addr, wdata, rdata, delay);
        @(negedge clk);
        check("stall_after", bus.core_stall, 0);
        check("gnt_after", {bus.ls_gnt, bus.if_gnt}, 2'b00);
    endtask

    initial begin
        rst           = 1'b1;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.ls_req    = 1'b0;
        bus.ls_we     = 1'b0;
        bus.ls_be     = '0;
        bus.ls_addr   = '0;
        bus.ls_wdata  = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;

        #12;
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_gnt", {bus.ls_gnt, bus.if_gnt}, 2'b00);
        check("rst_rvalid", {bus.ls_rvalid, bus.if_rvalid}, 2'b00);
        check("rst_rdata", {bus.ls_rdata, bus.if_rdata}, 64'h0);
        check("rst_mem_fields", {bus.mem_we, bus.mem_be, bus.mem_addr}, 0);
        check("rst_stall", bus.core_stall, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // fetch, memory answers two cycles after mem_req
        single(1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0, 32'h0050_0093, 2);
        // store: rdata must read back as zero
        single(1'b1, 1'b1, 4'b0011, 32'h0000_2000, 32'hDEAD_BEEF, 32'h1234_5678, 1);
        // zero-wait load and fetch
        single(1'b1, 1'b0, 4'hF, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 0);
        single(1'b0, 1'b0, 4'h0, 32'h0000_0104, 32'h0, 32'h0010_0113, 0);

        // reset in the middle of BUSY
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 4'h0, 32'h0000_0300, 32'h0);
        expect_gnt(1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("busy_mem_req", bus.mem_req, 1);
        #2 rst = 1'b1;
        #1 check("rst_async_mem_req", bus.mem_req, 0);
        bus.if_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_rvalid", {bus.ls_rvalid, bus.if_rvalid}, 2'b00);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // tie straight after reset: LS first, then IF on the cycle after LS rvalid
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 4'h0, 32'h0000_0180, 32'h0);
        drive_req(1'b1, 1'b0, 4'hF, 32'h0000_2004, 32'h0);
        expect_gnt(1'b1);
        serve(1'b1, 1'b0, 4'hF, 32'h0000_2004, 32'h0, 32'h0000_00AA, 1);
        expect_gnt(1'b0);
        serve(1'b0, 1'b0, 4'h0, 32'h0000_0180, 32'h0, 32'h0010_0073, 1);

        // second tie alternates back to LS
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 4'h0, 32'h0000_0184, 32'h0);
        drive_req(1'b1, 1'b1, 4'b1100, 32'h0000_2008, 32'h5555_AAAA);
        expect_gnt(1'b1);
        serve(1'b1, 1'b1, 4'b1100, 32'h0000_2008, 32'h5555_AAAA, 32'h7777_7777, 0);
        expect_gnt(1'b0);
        serve(1'b0, 1'b0, 4'h0, 32'h0000_0184, 32'h0, 32'h0020_0093, 2);
        @(negedge clk);
        check("stall_idle", bus.core_stall, 0);

`ifdef MEM_ARB_TIMEOUT_EN
        // no mem_ready: abort after four BUSY cycles with bus_err and zero data
        begin
            exp_t e;
            @(posedge clk); #1;
            bus.mem_rdata = 32'hFFFF_FFFF;
            drive_req(1'b0, 1'b0, 4'h0, 32'h0000_0400, 32'h0);
            expect_gnt(1'b0);
            e.owner = 1'b0;
            e.rdata = 32'h0;
            e.err   = 1'b1;
            sb.push_back(e);
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                @(negedge clk);
                check("to_mem_req", bus.mem_req, 1);
            end
            @(posedge clk); #1;
            @(negedge clk);
            check("to_mem_req_drop", bus.mem_req, 0);
            check("to_rvalid", bus.if_rvalid, 1);
            @(posedge clk); #1;
            bus.if_req = 1'b0;
        end
        // mem_ready on the expiring cycle completes normally
        single(1'b1, 1'b0, 4'hF, 32'h0000_2010, 32'h0, 32'h0BAD_CAFE, 3);
`endif

        repeat (2) @(posedge clk);
        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
